// File: rtl/rram_cmd_fifo.sv
// Show-ahead command/data FIFO with active-low push/pop strobes, sitting in front of rram_controller_fsm.
// Optional high-water-mark output is enabled with `define RRAM_CMD_FIFO_HWM_EN.
module rram_cmd_fifo #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH+1)
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push_n,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  pop_n,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
`ifdef RRAM_CMD_FIFO_HWM_EN
    output logic [CW-1:0]         hwm,
`endif
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  push_ok, pop_ok;

    // Status comes only from registered pointers/count, so no din/strobe reaches an output.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign dout         = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // A pop frees a slot on the same edge, so a full FIFO still takes a push alongside it.
    assign pop_ok    = !flush && !pop_n && !empty;
    assign push_ok   = !flush && !push_n && (!full || pop_ok);
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            if (!push_n && !push_ok) overflow  <= 1'b1;
            if (!pop_n && empty)     underflow <= 1'b1;
        end
    end

`ifdef RRAM_CMD_FIFO_HWM_EN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)              hwm <= '0;
        else if (flush)            hwm <= '0;
        else if (count_nxt > hwm)  hwm <= count_nxt;
    end
`endif

`ifndef SYNTHESIS
    a_strobe_known: assert property (@(posedge CLK) disable iff (!reset_n)
        !$isunknown({push_n, pop_n}))
        else $error("rram_cmd_fifo: X on push_n/pop_n");
`endif

endmodule

// File: tb/tb_rram_cmd_fifo.sv
// Directed self-checking bench for rram_cmd_fifo (DATA_WIDTH=20, DEPTH=16).
module tb_rram_cmd_fifo;

    localparam int DW = 20;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          reset_n, flush, push_n, pop_n;
    logic [DW-1:0] din, dout;
    logic          full, almost_full, empty, almost_empty, overflow, underflow;
    logic [CW-1:0] count;
`ifdef RRAM_CMD_FIFO_HWM_EN
    logic [CW-1:0] hwm;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    rram_cmd_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .CLK(CLK), .reset_n(reset_n), .flush(flush),
        .push_n(push_n), .din(din), .full(full), .almost_full(almost_full),
        .pop_n(pop_n), .dout(dout), .empty(empty), .almost_empty(almost_empty),
        .count(count),
`ifdef RRAM_CMD_FIFO_HWM_EN
        .hwm(hwm),
`endif
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic cyc(input logic ph, input logic pp, input logic [DW-1:0] d);
        push_n = ph; pop_n = pp; din = d;
        @(posedge CLK); #1;
        push_n = 1'b1; pop_n = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] d); cyc(1'b0, 1'b1, d); endtask
    task automatic pop();                         cyc(1'b1, 1'b0, '0); endtask

    task automatic do_flush(input logic ph);
        flush = 1'b1; push_n = ph; din = 20'h5_5555;
        @(posedge CLK); #1;
        flush = 1'b0; push_n = 1'b1;
    endtask

    task automatic chk_empty_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; push_n = 1'b1; pop_n = 1'b1; din = '0;
        #3;
        chk_empty_state("rst");
        #9 reset_n = 1'b1;
        @(posedge CLK); #1;

        // Basic show-ahead
        push_n = 1'b0; din = 20'h7_0600;
        @(posedge CLK); #1;
        chk("b_dout1", dout, 20'h7_0600);
        chk("b_cnt1", count, 1);
        din = 20'h7_0A00;
        @(posedge CLK); #1;
        push_n = 1'b1;
        chk("b_cnt2", count, 2);
        chk("b_head", dout, 20'h7_0600);
        pop();
        chk("b_dout2", dout, 20'h7_0A00);
        chk("b_cnt3", count, 1);
        pop();
        chk("b_empty", empty, 1);
        chk("b_dout0", dout, 0);
        chk("b_cnt0", count, 0);

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            push(DW'(i));
            chk($sformatf("f_af%0d", i), almost_full, (i + 1) >= 12);
            chk($sformatf("f_full%0d", i), full, (i + 1) == 16);
        end
        chk("f_ovf0", overflow, 0);
        push(20'h9_9999);
        chk("f_ovf1", overflow, 1);
        chk("f_cnt16", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("f_ord%0d", i), dout, DW'(i));
            pop();
            chk($sformatf("f_ae%0d", i), almost_empty, (15 - i) <= 2);
        end
        chk("f_empty", empty, 1);
        chk("f_unf0", underflow, 0);

        // Underflow and simultaneous push/pop
        pop();
        chk("u_unf", underflow, 1);
        chk("u_cnt", count, 0);
        cyc(1'b0, 1'b0, 20'h4_0000);
        chk("s_e_cnt", count, 1);
        chk("s_e_dout", dout, 20'h4_0000);
        for (int i = 0; i < 15; i++) push(DW'(20'h100 + i));
        chk("s_full", full, 1);
        cyc(1'b0, 1'b0, 20'hA_BCDE);
        chk("s_f_cnt", count, 16);
        chk("s_f_full", full, 1);
        chk("s_f_head", dout, 20'h100);

        // Flush with push_n low: both flags set, FIFO full
        chk("fl_pre_ovf", overflow, 1);
        chk("fl_pre_unf", underflow, 1);
        do_flush(1'b0);
        chk_empty_state("fl");
        @(posedge CLK); #1;
        chk("fl_disc", count, 0);

        // Flush from a partial fill
        for (int i = 0; i < 9; i++) push(DW'(20'h200 + i));
        chk("fl9_cnt", count, 9);
        do_flush(1'b0);
        chk_empty_state("fl9");

        // Streaming across two pointer wraps
        for (int i = 0; i < 3; i++) push(DW'(20'h1000 + i));
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("w_ord%0d", i), dout, DW'(20'h1000 + i));
            cyc(1'b0, 1'b0, DW'(20'h1003 + i));
            chk($sformatf("w_cnt%0d", i), count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w_tail%0d", i), dout, DW'(20'h1028 + i));
            pop();
        end
        chk("w_empty", empty, 1);

        // Asynchronous reset mid-stream
        pop();
        for (int i = 0; i < 9; i++) push(DW'(20'h300 + i));
        chk("r_pre_cnt", count, 9);
        chk("r_pre_unf", underflow, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_empty_state("r");
        #4 reset_n = 1'b1;
        @(posedge CLK); #1;
        push(20'h7_7777);
        chk("r_post_dout", dout, 20'h7_7777);
        chk("r_post_cnt", count, 1);
        pop();

`ifdef RRAM_CMD_FIFO_HWM_EN
        for (int i = 0; i < 10; i++) push(DW'(i));
        for (int i = 0; i < 6; i++) pop();
        for (int i = 0; i < 3; i++) push(DW'(i));
        chk("h_cnt", count, 7);
        chk("h_hwm", hwm, 10);
        do_flush(1'b1);
        chk("h_flush", hwm, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
